// File: rtl/sram_dma_burst_ctrl.sv
// sram_dma_burst_ctrl: burst sequencer for the SRAM DMA port with 2-entry read buffer and starvation flag
module sram_dma_burst_ctrl #(
    parameter int ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH   = 256,
    parameter int LEN_WIDTH    = 12,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  starve
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
    state_t state, next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] fifo [2];
    logic wp, rp, inflight;
    logic [1:0] cnt;
    logic [SW-1:0] stall;
    logic accept, wbeat, rbeat, pop, stalled;

    assign cmd_ready = state == IDLE;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign mem_addr  = addr;
    assign mem_we    = state == WRITE && wr_valid;
    assign mem_wdata = state == WRITE ? wr_data : '0;
    assign wr_ready  = mem_we && mem_ready;
    assign rd_valid  = cnt != 2'd0;
    assign rd_data   = rd_valid ? fifo[rp] : '0;
    assign pop       = rd_valid && rd_ready;
    // a same-cycle pop frees the slot the new read will land in, keeping 1 word/cycle
    assign mem_re    = state == READ && (int'(cnt) + int'(inflight) < 2 + int'(pop));
    assign wbeat     = mem_we && mem_ready;
    assign rbeat     = mem_re && mem_ready;
    assign stalled   = (mem_we || mem_re) && !mem_ready;
    assign starve    = stall == SW'(STARVE_LIMIT);

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (accept) next = cmd_len == '0 ? DONE : cmd_write ? WRITE : READ;
            WRITE:   if (wbeat && rem == LEN_WIDTH'(1)) next = DONE;
            READ:    if (rbeat && rem == LEN_WIDTH'(1)) next = DRAIN;
            DRAIN:   if (cnt == 2'd0 && !inflight) next = DONE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            rem      <= '0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            cnt      <= 2'd0;
            inflight <= 1'b0;
            stall    <= '0;
        end else begin
            state    <= next;
            inflight <= rbeat;
            if (accept) begin
                addr <= cmd_addr;
                rem  <= cmd_len;
            end else if (wbeat || rbeat) begin
                addr <= addr + 1'b1;
                rem  <= rem - 1'b1;
            end
            if (inflight) wp <= ~wp;
            if (pop) rp <= ~rp;
            cnt   <= cnt + {1'b0, inflight} - {1'b0, pop};
            stall <= (state == IDLE || wbeat || rbeat) ? '0 :
                     (stalled && !starve) ? stall + 1'b1 : stall;
        end
    end

    always_ff @(posedge clk)
        if (inflight) fifo[wp] <= mem_rdata;
endmodule

// File: tb/tb_sram_dma_burst_ctrl.sv
// tb_sram_dma_burst_ctrl: directed self-checking bench for sram_dma_burst_ctrl
module tb_sram_dma_burst_ctrl;
    localparam int AW = 20;
    localparam int DW = 256;
    localparam int LW = 12;
    localparam int SL = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic wr_valid = 1'b0, wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic rd_valid, rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic mem_we, mem_re, mem_ready = 1'b1;
    logic [DW-1:0] mem_rdata = '0;
    logic busy, done, starve;
    int checks = 0;
    int failures = 0;

    sram_dma_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .busy(busy), .done(done), .starve(starve)
    );

    always #5 clk = ~clk;

    // SRAM model: read data equals the word address, one cycle after an accepted read
    always @(posedge clk)
        if (mem_re && mem_ready) mem_rdata <= DW'(mem_addr);

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic issue_cmd(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        @(negedge clk);
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (done) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_done_timeout got=0 want=1", name);
        end
        @(negedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle cmd_ready=%b busy=%b want 1 0", name, cmd_ready, busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wr_valid = 1'b1;
        wr_data = DW'(32'hDEAD_BEEF);
        cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, busy, done, mem_we, mem_re, rd_valid, wr_ready, starve} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=10000000",
                     {cmd_ready, busy, done, mem_we, mem_re, rd_valid, wr_ready, starve});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || rd_data !== '0) begin
            failures++;
            $display("FAIL reset_data addr=%h wdata=%h rdata=%h want zeros", mem_addr, mem_wdata, rd_data);
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_write;
        mem_ready = 1'b1;
        wr_valid = 1'b1;
        issue_cmd(1'b1, 20'h00100, 12'd4);
        for (int i = 0; i < 4; i++) begin
            wr_data = DW'(32'hA0 + i);
            #1;
            checks++;
            if (mem_we !== 1'b1 || wr_ready !== 1'b1 || mem_addr !== AW'(20'h100 + i) || mem_wdata !== DW'(32'hA0 + i) || done !== 1'b0) begin
                failures++;
                $display("FAIL write_beat%0d we=%b wr_ready=%b addr=%h wdata=%h done=%b want 1 1 %h %h 0",
                         i, mem_we, wr_ready, mem_addr, mem_wdata, done, 20'h100 + i, 32'hA0 + i);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (done !== 1'b1 || mem_we !== 1'b0 || wr_ready !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL write_done done=%b we=%b wr_ready=%b cmd_ready=%b want 1 0 0 0", done, mem_we, wr_ready, cmd_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL write_idle done=%b cmd_ready=%b busy=%b want 0 1 0", done, cmd_ready, busy);
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_read_backpressure;
        int k = 0;
        int n = 0;
        bit seen = 0;
        rd_ready = 1'b0;
        mem_ready = 1'b1;
        issue_cmd(1'b0, 20'h00200, 12'd3);
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (mem_re !== (c < 2) || (c < 2 && mem_addr !== AW'(20'h200 + c))) begin
                failures++;
                $display("FAIL read_throttle_c%0d re=%b addr=%h want re=%b", c, mem_re, mem_addr, c < 2);
            end
            @(negedge clk);
        end
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== DW'(20'h200)) begin
            failures++;
            $display("FAIL read_head valid=%b data=%h want 1 200", rd_valid, rd_data);
        end
        rd_ready = 1'b1;
        for (int c = 0; c < 12 && !seen; c++) begin
            #1;
            if (rd_valid) begin
                checks++;
                if (rd_data !== DW'(20'h200 + k)) begin
                    failures++;
                    $display("FAIL read_data%0d got=%h want=%h", k, rd_data, 20'h200 + k);
                end
                k++;
            end
            if (mem_re) begin
                checks++;
                if (mem_addr !== 20'h00202) begin
                    failures++;
                    $display("FAIL read_third_addr got=%h want=00202", mem_addr);
                end
                n++;
            end
            if (done) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (k != 3 || n != 1 || !seen) begin
            failures++;
            $display("FAIL read_counts words=%0d issues=%0d done=%b want 3 1 1", k, n, seen);
        end
        @(negedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_idle cmd_ready=%b rd_valid=%b want 1 0", cmd_ready, rd_valid);
        end
    endtask

    task automatic test_starve;
        int bad = 0;
        wr_valid = 1'b1;
        mem_ready = 1'b0;
        issue_cmd(1'b1, 20'h00300, 12'd2);
        for (int i = 0; i < 70; i++) begin
            #1;
            if (starve !== (i >= SL) || wr_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL starve_ramp bad_cycles=%0d want=0", bad);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (starve !== 1'b1 || wr_ready !== 1'b1 || mem_addr !== 20'h00300) begin
            failures++;
            $display("FAIL starve_hold starve=%b wr_ready=%b addr=%h want 1 1 00300", starve, wr_ready, mem_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (starve !== 1'b0 || mem_addr !== 20'h00301) begin
            failures++;
            $display("FAIL starve_clear starve=%b addr=%h want 0 00301", starve, mem_addr);
        end
        wait_done("starve");
        wr_valid = 1'b0;
    endtask

    task automatic test_zero_len;
        wr_valid = 1'b1;
        @(negedge clk);
        cmd_write = 1'b1;
        cmd_addr = 20'h00500;
        cmd_len = '0;
        cmd_valid = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL zlen_pre busy=%b cmd_ready=%b want 0 1", busy, cmd_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b1 || mem_we !== 1'b0 || mem_re !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL zlen_done busy=%b done=%b we=%b re=%b cmd_ready=%b want 1 1 0 0 0",
                     busy, done, mem_we, mem_re, cmd_ready);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL zlen_after busy=%b done=%b we=%b want 0 0 0", busy, done, mem_we);
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_wrap;
        logic [AW-1:0] exp_a [2];
        exp_a[0] = 20'hFFFFF;
        exp_a[1] = 20'h00000;
        rd_ready = 1'b1;
        mem_ready = 1'b1;
        issue_cmd(1'b0, 20'hFFFFF, 12'd2);
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (c < 2 && (mem_re !== 1'b1 || mem_addr !== exp_a[c])) begin
                failures++;
                $display("FAIL wrap_addr%0d re=%b addr=%h want 1 %h", c, mem_re, mem_addr, exp_a[c]);
            end
            if (c >= 2 && (rd_valid !== 1'b1 || rd_data !== DW'(exp_a[c-2]))) begin
                failures++;
                $display("FAIL wrap_data%0d valid=%b data=%h want 1 %h", c - 2, rd_valid, rd_data, exp_a[c-2]);
            end
            @(negedge clk);
        end
        wait_done("wrap");
    endtask

    task automatic test_back_to_back;
        int bad = 0;
        int k = 0;
        rd_ready = 1'b1;
        mem_ready = 1'b1;
        issue_cmd(1'b0, 20'h00600, 12'd4);
        for (int c = 0; c < 8; c++) begin
            #1;
            if (mem_re !== (c < 4) || rd_valid !== (c >= 2 && c < 6) || done !== (c == 7)) bad++;
            if (c < 4 && mem_addr !== AW'(20'h600 + c)) bad++;
            if (rd_valid) begin
                if (rd_data !== DW'(20'h600 + k)) bad++;
                k++;
            end
            if (c < 7) @(negedge clk);
        end
        checks++;
        if (bad != 0 || k != 4) begin
            failures++;
            $display("FAIL b2b_stream bad=%0d words=%0d want 0 4", bad, k);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        rd_ready = 1'b0;
        mem_ready = 1'b1;
        issue_cmd(1'b0, 20'h00400, 12'd3);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== DW'(20'h400) || busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre valid=%b data=%h busy=%b want 1 400 1", rd_valid, rd_data, busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_post valid=%b busy=%b cmd_ready=%b done=%b want 0 0 1 0", rd_valid, busy, cmd_ready, done);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (rd_valid !== 1'b0 || done !== 1'b0 || mem_re !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_quiet%0d valid=%b done=%b re=%b busy=%b want 0 0 0 0", c, rd_valid, done, mem_re, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_backpressure();
        test_starve();
        test_zero_len();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
